// File: rtl/coin_input_conditioner_if.sv
`default_nettype none
// ============================================================================
// coin_input_conditioner_if : raw coin sensors, FSM handshake and coin pulses
// Rev 1.0
// ============================================================================
interface coin_input_conditioner_if #(
   parameter int DEPTH = 4
) ();
   logic                    coin5_raw;
   logic                    coin10_raw;
   logic                    coin25_raw;
   logic                    accept_ready;
   logic                    c5;
   logic                    c10;
   logic                    c25;
   logic [$clog2(DEPTH):0]  pending;
   logic                    overflow;
   logic                    coin_reject;

   modport master (
      output coin5_raw, coin10_raw, coin25_raw, accept_ready,
      input  c5, c10, c25, pending, overflow, coin_reject
   );

   modport slave (
      input  coin5_raw, coin10_raw, coin25_raw, accept_ready,
      output c5, c10, c25, pending, overflow, coin_reject
   );
endinterface
`default_nettype wire

// File: rtl/coin_input_conditioner.sv
`default_nettype none
// ============================================================================
// coin_input_conditioner : debounced coin sensors -> queued one-hot coin pulses
// Rev 1.0
// ============================================================================
module coin_input_conditioner #(
   parameter int DB_CYCLES = 4,
   parameter int DEPTH     = 4,
   parameter int HOLD_MAX  = 8
) (
   input  logic                    clk,
   input  logic                    reset_n,
   coin_input_conditioner_if.slave coin_if
);
   localparam int                c_PW        = $clog2(DEPTH);
   localparam int                c_HW        = $clog2(HOLD_MAX + 1);
   localparam logic [7:0]        c_DB_LAST   = 8'(DB_CYCLES - 1);
   localparam logic [c_HW-1:0]   c_HOLD_LAST = c_HW'(HOLD_MAX - 1);
   localparam logic [c_PW:0]     c_FULL      = (c_PW + 1)'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_HOLD  = 2'd2
   } state_t;

   logic [2:0]      w_raw;
   logic [2:0]      w_evt;
   logic [1:0]      r_warm;
   logic            w_warm;
   logic            w_one;
   logic            w_multi;
   logic [1:0]      w_code;
   logic            w_full;
   logic            w_push;
   logic            w_pop;
   logic [1:0]      w_head;
   logic [1:0]      r_mem [DEPTH];
   logic [c_PW-1:0] r_wr;
   logic [c_PW-1:0] r_rd;
   logic [c_PW:0]   r_pending;
   logic            r_overflow;
   logic            r_reject;
   state_t          r_state;
   state_t          w_next;
   logic [c_HW-1:0] r_hold;
   logic            r_c5, r_c10, r_c25;
   logic            w_c5, w_c10, w_c25;

   assign w_raw  = {coin_if.coin25_raw, coin_if.coin10_raw, coin_if.coin5_raw};
   assign w_warm = r_warm[1];

   // Arming waits until the synchronisers hold real samples, so a sensor
   // already high at reset release is never mistaken for a fresh coin.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_warm <= 2'd0;
      end else if (!r_warm[1]) begin
         r_warm <= r_warm + 2'd1;
      end
   end

   generate
      for (genvar g = 0; g < 3; g++) begin : g_ch
         logic       r_s1, r_s2, r_deb, r_deb_d, r_arm;
         logic [7:0] r_cnt;

         always_ff @(posedge clk) begin
            if (!reset_n) begin
               r_s1    <= 1'b0;
               r_s2    <= 1'b0;
               r_deb   <= 1'b0;
               r_deb_d <= 1'b0;
               r_arm   <= 1'b0;
               r_cnt   <= 8'd0;
            end else begin
               r_s1    <= w_raw[g];
               r_s2    <= r_s1;
               r_deb_d <= r_deb;
               if (r_s2 == r_deb) begin
                  r_cnt <= 8'd0;
               end else if (r_cnt == c_DB_LAST) begin
                  r_deb <= r_s2;
                  r_cnt <= 8'd0;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
               if (w_warm && !r_s2 && !r_deb) begin
                  r_arm <= 1'b1;
               end
            end
         end

         assign w_evt[g] = r_deb & ~r_deb_d & r_arm;
      end
   endgenerate

   assign w_one   = $onehot(w_evt);
   assign w_multi = (w_evt != 3'b000) && !w_one;
   assign w_code  = {w_evt[2] | w_evt[1], w_evt[2] | w_evt[0]};
   assign w_full  = (r_pending == c_FULL);
   assign w_push  = w_one && (!w_full || w_pop);
   assign w_head  = r_mem[r_rd];

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_wr       <= '0;
         r_rd       <= '0;
         r_pending  <= '0;
         r_overflow <= 1'b0;
         r_reject   <= 1'b0;
      end else begin
         if (w_push) begin
            r_mem[r_wr] <= w_code;
            r_wr        <= r_wr + c_PW'(1);
         end
         if (w_pop) begin
            r_rd <= r_rd + c_PW'(1);
         end
         r_pending  <= r_pending + (c_PW + 1)'(w_push) - (c_PW + 1)'(w_pop);
         r_overflow <= w_one && w_full && !w_pop;
         r_reject   <= w_multi;
      end
   end

   // The holdoff window is measured from the pulse cycle itself.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_hold  <= '0;
         r_c5    <= 1'b0;
         r_c10   <= 1'b0;
         r_c25   <= 1'b0;
      end else begin
         r_state <= w_next;
         r_c5    <= w_c5;
         r_c10   <= w_c10;
         r_c25   <= w_c25;
         if (r_state == S_ISSUE) begin
            r_hold <= c_HW'(1);
         end else if (r_state == S_HOLD) begin
            r_hold <= r_hold + c_HW'(1);
         end
      end
   end

   always_comb begin
      w_next = r_state;
      w_pop  = 1'b0;
      w_c5   = 1'b0;
      w_c10  = 1'b0;
      w_c25  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if ((r_pending != '0) && coin_if.accept_ready) begin
               w_next = S_ISSUE;
               w_pop  = 1'b1;
               w_c5   = (w_head == 2'b01);
               w_c10  = (w_head == 2'b10);
               w_c25  = (w_head == 2'b11);
            end
         end
         S_ISSUE: begin
            w_next = S_HOLD;
         end
         S_HOLD: begin
            if (!coin_if.accept_ready || (r_hold >= c_HOLD_LAST)) begin
               w_next = S_IDLE;
            end
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   assign coin_if.c5          = r_c5;
   assign coin_if.c10         = r_c10;
   assign coin_if.c25         = r_c25;
   assign coin_if.pending     = r_pending;
   assign coin_if.overflow    = r_overflow;
   assign coin_if.coin_reject = r_reject;
endmodule
`default_nettype wire
